// File: rtl/alpha_seq.sv
// Alpha blender for 4-bit RGB pixels using one time-shared 4x4 multiplier over six steps.
// Optional ALPHA_FASTPATH_EN: alpha 0/15 bypass the multiplier and finish in one cycle.
module alpha_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] r0,
  input  logic [3:0] g0,
  input  logic [3:0] b0,
  input  logic [3:0] r1,
  input  logic [3:0] g1,
  input  logic [3:0] b1,
  input  logic [3:0] alpha,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] rout,
  output logic [3:0] gout,
  output logic [3:0] bout,
  output logic       busy
);

  localparam int unsigned CW = 4;
  localparam int unsigned PW = 8;
  localparam int unsigned SW = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [SW-1:0] LAST_STEP = SW'(5);
  localparam logic [CW-1:0] FULL      = CW'(15);

  logic [1:0]    state, state_next;
  logic [SW-1:0] step, step_next;
  logic [PW-1:0] acc, acc_next;
  logic [CW-1:0] op_r0, op_g0, op_b0, op_r1, op_g1, op_b1, op_alpha;
  logic [CW-1:0] op_r0_next, op_g0_next, op_b0_next;
  logic [CW-1:0] op_r1_next, op_g1_next, op_b1_next, op_alpha_next;
  logic [CW-1:0] res_r, res_g, res_r_next, res_g_next;
  logic [CW-1:0] rout_next, gout_next, bout_next;

  logic [CW-1:0] mul_a, mul_b;
  logic [PW-1:0] prod, chan_sum, sum_rnd;
  logic [CW-1:0] chan_res;

  // Shared multiplier: even steps weight the background, odd steps the foreground.
  always_comb begin
    case (step)
      SW'(0):  mul_a = op_r0;
      SW'(1):  mul_a = op_r1;
      SW'(2):  mul_a = op_g0;
      SW'(3):  mul_a = op_g1;
      SW'(4):  mul_a = op_b0;
      default: mul_a = op_b1;
    endcase
    mul_b    = step[0] ? op_alpha : (FULL - op_alpha);
    prod     = PW'(mul_a) * PW'(mul_b);
    chan_sum = acc + prod;
    sum_rnd  = chan_sum + (chan_sum >> 4) + PW'(8);
    chan_res = CW'(sum_rnd >> 4);
  end

  // Next-state and datapath update.
  always_comb begin
    state_next    = state;
    step_next     = step;
    acc_next      = acc;
    op_r0_next    = op_r0;
    op_g0_next    = op_g0;
    op_b0_next    = op_b0;
    op_r1_next    = op_r1;
    op_g1_next    = op_g1;
    op_b1_next    = op_b1;
    op_alpha_next = op_alpha;
    res_r_next    = res_r;
    res_g_next    = res_g;
    rout_next     = rout;
    gout_next     = gout;
    bout_next     = bout;

    case (state)
      IDLE: begin
        if (in_valid) begin
          op_r0_next    = r0;
          op_g0_next    = g0;
          op_b0_next    = b0;
          op_r1_next    = r1;
          op_g1_next    = g1;
          op_b1_next    = b1;
          op_alpha_next = alpha;
          acc_next      = '0;
          step_next     = '0;
          state_next    = MUL;
`ifdef ALPHA_FASTPATH_EN
          if (alpha == '0) begin
            rout_next  = r0;
            gout_next  = g0;
            bout_next  = b0;
            state_next = DONE;
          end else if (alpha == FULL) begin
            rout_next  = r1;
            gout_next  = g1;
            bout_next  = b1;
            state_next = DONE;
          end
`endif
        end
      end
      MUL: begin
        if (!step[0]) begin
          acc_next = prod;
        end else begin
          case (step)
            SW'(1): res_r_next = chan_res;
            SW'(3): res_g_next = chan_res;
            default: begin
              rout_next = res_r;
              gout_next = res_g;
              bout_next = chan_res;
            end
          endcase
        end
        if (step == LAST_STEP) begin
          step_next  = '0;
          state_next = DONE;
        end else begin
          step_next = step + SW'(1);
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset wins over every handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      step      <= '0;
      acc       <= '0;
      op_r0     <= '0;
      op_g0     <= '0;
      op_b0     <= '0;
      op_r1     <= '0;
      op_g1     <= '0;
      op_b1     <= '0;
      op_alpha  <= '0;
      res_r     <= '0;
      res_g     <= '0;
      rout      <= '0;
      gout      <= '0;
      bout      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      step      <= step_next;
      acc       <= acc_next;
      op_r0     <= op_r0_next;
      op_g0     <= op_g0_next;
      op_b0     <= op_b0_next;
      op_r1     <= op_r1_next;
      op_g1     <= op_g1_next;
      op_b1     <= op_b1_next;
      op_alpha  <= op_alpha_next;
      res_r     <= res_r_next;
      res_g     <= res_g_next;
      rout      <= rout_next;
      gout      <= gout_next;
      bout      <= bout_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule
